addsub_multicycle: RTL
======================

# addsub_multicycle

Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, least-significant digit first, with a start/busy/done handshake and carry, overflow and zero flags. It generalises the team's 4-bit combinational adder/subtractor to arbitrary widths. Datapath area is traded for latency, so one small DIGIT-bit slice serves wide operands. It sits behind a control FSM or register interface that launches one operation at a time and collects the registered result.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- DIGIT, 4: bits processed per cycle; must divide WIDTH exactly. DIGIT = WIDTH gives single-pass operation.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. The one clock and the asynchronous active-low reset are fixed decisions.
- start  in  1  launch request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- mode  in  1  0 = add (a+b), 1 = subtract (a−b); sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  result == 0.

## Operation
- N = WIDTH/DIGIT digit cycles per operation.
- States and transitions:
  - IDLE: on start, latch a, latch b XOR {WIDTH{mode}}, and set carry register = mode. Go to RUN with digit index 0.
  - RUN: each cycle add digit[idx] of A, digit[idx] of B' and the carry register. Write the DIGIT-bit sum into the result shift register and update the carry register. idx increments each cycle; after idx = N−1, go to DONE.
  - DONE: done = 1 for this cycle. With start, relaunch exactly as from IDLE; otherwise go to IDLE.
- On the final digit, capture the carry into the MSB from the slice and compute ovf from it.
- zero is computed from the completed result at the transition into DONE.
- Holding rules:
  - result, cout, ovf and zero hold their values from DONE until the next DONE. They do not clear on the next start.
  - start while busy is ignored; no queueing. Input operand changes during RUN have no effect.
- Reset (any time, including mid-RUN) returns to IDLE immediately and discards the partial operation. Reset values: busy 0, done 0, result 0, cout 0, ovf 0, zero 0. zero resets to 0 even though result = 0.

## Timing
- Accepting edge = E0. busy is high after E0 through the edge that completes the last digit (E_N).
- done is high for the single cycle after E_N, with outputs updated on that same edge E_N.
- Latency from start to done: N edges. For WIDTH=16 and DIGIT=4, done is seen after the 4th edge following acceptance.
- Back-to-back throughput: start held continuously gives one result every N+1 cycles. The DONE cycle doubles as the launch cycle.
- For DIGIT = WIDTH: N = 1, so RUN lasts one cycle, then DONE.
- Reset deassertion is the synchronous user's responsibility; the first accepting edge is the first edge with rst_n high.

## Structure
- Package addsub_pkg holds shared definitions:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - mode constants MODE_ADD = 0, MODE_SUB = 1;
  - a parameter-check function/macro enforcing WIDTH % DIGIT == 0.
- One sub-module, addsub_digit:
  - combinational DIGIT-bit ripple adder;
  - inputs x, y, cin; outputs s, cout, c_msb_in (carry into its top bit).
- The top level owns the FSM, digit counter (width clog2(N), minimum 1), operand shift registers, carry register and output registers.

## Test plan
All cases use WIDTH=16, DIGIT=4.
- 0x1234 + 0x0FFF, mode 0 → result 0x2233, cout 0, ovf 0, zero 0. busy high for exactly 4 cycles; done a single pulse.
- 0x7FFF + 0x0001 → 0x8000, ovf 1, cout 0. Then 0xFFFF + 0x0001 → 0x0000, cout 1, ovf 0, zero 1.
- 0x0005 − 0x0007 (mode 1) → 0xFFFE, cout 0 (borrow), ovf 0. Then 0x8000 − 0x0001 → 0x7FFF, cout 1, ovf 1.
- Handshake:
  - start pulsed mid-RUN with different operands → ignored; the first result completes unchanged.
  - start held high → consecutive done pulses spaced 5 cycles apart.
- Reset:
  - rst_n low during digit 2 → busy, done and all outputs 0 immediately; IDLE.
  - a new 0x1234 − 0x1234 after reset → 0x0000, zero 1, cout 1.
- Repeat a 1000-vector random sweep (add and subtract mix) against a reference model with DIGIT = 1, 8 and 16; the DIGIT = 16 run must show 1-cycle busy.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Legal geometry: at least 2 bits wide and the digit divides the width exactly.
  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its top bit.
module addsub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [DIGIT:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c      = '0;
    s_o    = '0;
    c[0]   = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
      c[i+1]   = (x_i[i] & y_i[i]) | (x_i[i] & c[i]) | (y_i[i] & c[i]);
    end
  end

  assign cout_o     = c[DIGIT];
  assign c_msb_in_o = c[DIGIT-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice walks the operands LSB digit first.
module addsub_multicycle
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned N       = WIDTH / DIGIT;
  localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("addsub_multicycle: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic             launch;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x_i        (a_q[DIGIT-1:0]),
    .y_i        (b_q[DIGIT-1:0]),
    .cin_i      (carry_q),
    .s_o        (dig_s),
    .cout_o     (dig_cout),
    .c_msb_in_o (dig_cmsb)
  );

  // A doubles as the result accumulator: sum digits enter at the top while A drains out the
  // bottom, so after N shifts it holds the complete result.
  if (N == 1) begin : g_single
    assign a_shift = dig_s;
    assign b_shift = '0;
  end else begin : g_multi
    assign a_shift = {dig_s, a_q[WIDTH-1:DIGIT]};
    assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end

  // Next-state logic: launch from IDLE/DONE, one digit per RUN cycle, publish on the last digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    launch   = 1'b0;

    unique case (state_q)
      ST_IDLE: launch = start_i;
      ST_RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = dig_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d  = ST_DONE;
          result_d = a_shift;
          cout_d   = dig_cout;
          ovf_d    = dig_cmsb ^ dig_cout;
          zero_d   = (a_shift == '0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        launch  = start_i;
      end
      default: state_d = ST_IDLE;
    endcase

    // Subtraction is a + ~b + 1: invert B and seed the carry with the mode bit.
    if (launch) begin
      state_d = ST_RUN;
      idx_d   = '0;
      a_d     = a_i;
      b_d     = (mode_i == MODE_ADD) ? b_i : ~b_i;
      carry_d = (mode_i == MODE_SUB);
    end
  end

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;

endmodule
